// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: sequencer state encoding and 74181 select/mode codes for common operations
package alu_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef struct packed {
    logic [3:0] s;
    logic       m;
  } alu_op_t;
  localparam alu_op_t ALU_ADD = '{s: 4'b1001, m: 1'b0};
  localparam alu_op_t ALU_SUB = '{s: 4'b0110, m: 1'b0};
  localparam alu_op_t ALU_XOR = '{s: 4'b0110, m: 1'b1};
  localparam alu_op_t ALU_AND = '{s: 4'b1011, m: 1'b1};
endpackage

// File: rtl/alu_settle_timer.sv
// alu_settle_timer: loadable down-counter that holds each nibble for N clocks
//  clk, reset_n : clock, async active-low reset
//  load         : reload with N-1 (start of a nibble)
//  en           : count down while nonzero
//  zero         : counter is 0, slice outputs may be sampled
module alu_settle_timer
  import alu_seq_pkg::*;
#(
  parameter int N = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic en,
  output logic zero
);
  localparam int CW = N > 1 ? $clog2(N) : 1;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (load) cnt <= CW'(N - 1);
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer: runs a W-bit op through one 4-bit 74181 slice, LS nibble first
//  req_*  : request handshake (S, M, carry in, operands A/B)
//  rsp_*  : response handshake (F, carry out, zero, AND of slice A=B)
//  alu_*  : registered drive to the slice, and its F / CN4b / A=B returns
module alu_nibble_sequencer
  import alu_seq_pkg::*;
#(
  parameter int W             = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [3:0]   req_s,
  input  logic         req_m,
  input  logic         req_cin,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_f,
  output logic         rsp_cout,
  output logic         rsp_zero,
  output logic         rsp_aeb,
  output logic [3:0]   alu_s,
  output logic         alu_m,
  output logic [3:0]   alu_a,
  output logic [3:0]   alu_b,
  output logic         alu_cnb,
  input  logic [3:0]   alu_f,
  input  logic         alu_cn4b,
  input  logic         alu_aeb
);
  localparam int NIB = W / 4;
  localparam int IW  = NIB > 1 ? $clog2(NIB) : 1;
  state_t         state_q, state_d;
  logic [3:0]     s_q;
  logic           m_q, carry_q, aeb_q;
  logic [W-1:0]   a_q, b_q, f_q;
  logic [IW-1:0]  idx;
  logic           accept, settled, sample, last;
  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == DONE;
  assign accept    = req_ready && req_valid;
  assign sample    = state_q == RUN && settled;
  assign last      = idx == IW'(NIB - 1);
  alu_settle_timer #(.N(SETTLE_CYCLES)) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (accept || (sample && !last)),
    .en     (state_q == RUN),
    .zero   (settled)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;
  // accept, final sample and response handshake are mutually exclusive by state
  always_comb begin
    state_d = state_q;
    if (accept) state_d = RUN;
    if (sample && last) state_d = DONE;
    if (rsp_valid && rsp_ready) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s_q     <= '0;
      m_q     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      f_q     <= '0;
      carry_q <= 1'b0;
      aeb_q   <= 1'b1;
      idx     <= '0;
    end else if (accept) begin
      s_q     <= req_s;
      m_q     <= req_m;
      a_q     <= req_a;
      b_q     <= req_b;
      carry_q <= req_cin;
      aeb_q   <= 1'b1;
      idx     <= '0;
    end else if (sample) begin
      f_q[{idx, 2'b00} +: 4] <= alu_f;
      carry_q                <= ~alu_cn4b;
      aeb_q                  <= aeb_q & alu_aeb;
      if (!last) idx <= idx + 1'b1;
    end
  // slice inputs come straight from registers so they stay glitch-free per nibble
  assign alu_s    = s_q;
  assign alu_m    = m_q;
  assign alu_a    = a_q[{idx, 2'b00} +: 4];
  assign alu_b    = b_q[{idx, 2'b00} +: 4];
  assign alu_cnb  = ~carry_q;
  assign rsp_f    = f_q;
  assign rsp_cout = carry_q;
  assign rsp_aeb  = aeb_q;
  assign rsp_zero = f_q == '0;
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// tb_alu_nibble_sequencer: scoreboard bench driving the sequencer against a delayed 74181 model
module tb_alu_nibble_sequencer;
  import alu_seq_pkg::*;
  localparam int W = 16;
  localparam int SETTLE = 2;
  localparam int LAT = (W / 4) * SETTLE;
  typedef struct packed {
    logic [W-1:0] f;
    logic         cout;
    logic         zero;
    logic         aeb;
    logic         m;
  } exp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic req_valid = 1'b0, req_m = 1'b0, req_cin = 1'b0, rsp_ready = 1'b1;
  logic [3:0] req_s = '0;
  logic [W-1:0] req_a = '0, req_b = '0;
  logic req_ready, rsp_valid, rsp_cout, rsp_zero, rsp_aeb, alu_m, alu_cnb, alu_cn4b, alu_aeb;
  logic [W-1:0] rsp_f;
  logic [3:0] alu_s, alu_a, alu_b, alu_f;
  exp_t sb[$];
  exp_t e;
  int n_chk = 0, n_fail = 0, cyc = 0, acc_cyc = 0;
  bit seen = 1'b0;
  alu_op_t ops[4] = '{ALU_ADD, ALU_SUB, ALU_XOR, ALU_AND};
  always #20 clk = ~clk;
  alu_nibble_sequencer #(.W(W), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_s(req_s), .req_m(req_m),
    .req_cin(req_cin), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_f(rsp_f), .rsp_cout(rsp_cout),
    .rsp_zero(rsp_zero), .rsp_aeb(rsp_aeb),
    .alu_s(alu_s), .alu_m(alu_m), .alu_a(alu_a), .alu_b(alu_b), .alu_cnb(alu_cnb),
    .alu_f(alu_f), .alu_cn4b(alu_cn4b), .alu_aeb(alu_aeb)
  );
  function automatic logic [5:0] m181(input logic [3:0] s, input logic m, input logic [3:0] a,
                                      input logic [3:0] b, input logic cnb);
    logic [3:0] p, g, l, f;
    logic [4:0] sum;
    p   = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    g   = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
    sum = {1'b0, p} + {1'b0, g} + {4'b0, ~cnb};
    case (s)
      4'h0: l = ~a;
      4'h1: l = ~(a | b);
      4'h2: l = ~a & b;
      4'h3: l = 4'h0;
      4'h4: l = ~(a & b);
      4'h5: l = ~b;
      4'h6: l = a ^ b;
      4'h7: l = a & ~b;
      4'h8: l = ~a | b;
      4'h9: l = ~(a ^ b);
      4'hA: l = b;
      4'hB: l = a & b;
      4'hC: l = 4'hF;
      4'hD: l = a | ~b;
      4'hE: l = a | b;
      default: l = a;
    endcase
    f = m ? l : sum[3:0];
    return {f == 4'hF, ~sum[4], f};
  endfunction
  assign #70 {alu_aeb, alu_cn4b, alu_f} = m181(alu_s, alu_m, alu_a, alu_b, alu_cnb);
  function automatic exp_t ref_op(alu_op_t op, logic [W-1:0] a, logic [W-1:0] b, logic cin);
    exp_t r;
    logic [W:0] v;
    v = op == ALU_ADD ? {1'b0, a} + {1'b0, b} + (W+1)'(cin) :
        op == ALU_SUB ? {1'b0, a} + {1'b0, ~b} + (W+1)'(cin) :
        op == ALU_XOR ? {1'b0, a ^ b} : {1'b0, a & b};
    r.f    = v[W-1:0];
    r.cout = v[W];
    r.zero = v[W-1:0] == '0;
    r.aeb  = &v[W-1:0];
    r.m    = op.m;
    return r;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(posedge clk) cyc++;
  always @(negedge clk)
    if (!reset_n) seen = 1'b0;
    else begin
      if (rsp_valid && !seen) begin
        seen = 1'b1;
        check("latency", cyc - acc_cyc, LAT);
      end
      if (rsp_valid && rsp_ready) begin
        seen = 1'b0;
        if (sb.size() == 0) check("unexpected_rsp", 1, 0);
        else begin
          e = sb.pop_front();
          check("rsp_f", rsp_f, e.f);
          check("rsp_zero", rsp_zero, e.zero);
          check("rsp_aeb", rsp_aeb, e.aeb);
          if (!e.m) check("rsp_cout", rsp_cout, e.cout);
        end
      end
    end
  task automatic send(input alu_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin);
    int t = 0;
    @(negedge clk);
    req_s = op.s; req_m = op.m; req_a = a; req_b = b; req_cin = cin; req_valid = 1'b1;
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      check("accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    sb.push_back(ref_op(op, a, b, cin));
    acc_cyc = cyc + 1;
    @(negedge clk);
    req_valid = 1'b0; req_a = ~a; req_b = W'($urandom); req_s = ~op.s; req_cin = ~cin;
  endtask
  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain", sb.size(), 0);
  endtask
  task automatic hold_check();
    int t = 0;
    while (!rsp_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    repeat (5) begin
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_req_ready", req_ready, 0);
      check("hold_f", rsp_f, 16'h1001);
      check("hold_cout", rsp_cout, 0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
  endtask
  initial begin
    int hits;
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_alu_cnb", alu_cnb, 1);
    check("rst_alu_s", alu_s, 0);
    check("rst_alu_m", alu_m, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_rsp_f", rsp_f, 0);
    #5 reset_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    send(ALU_ADD, 16'h1234, 16'h0FFF, 1'b0);
    send(ALU_ADD, 16'hFFFF, 16'h0001, 1'b0);
    send(ALU_SUB, 16'h5000, 16'h1234, 1'b1);
    send(ALU_SUB, 16'hBEEF, 16'hBEEF, 1'b0);
    send(ALU_XOR, 16'hF0F0, 16'h3C3C, 1'b0);
    send(ALU_AND, 16'hF0F0, 16'h3C3C, 1'b0);
    drain();
    rsp_ready = 1'b0;
    send(ALU_ADD, 16'h00FF, 16'h0F01, 1'b1);
    fork
      send(ALU_SUB, 16'h8000, 16'h0001, 1'b0);
      hold_check();
    join
    drain();
    repeat (8) send(ops[$urandom_range(0, 3)], W'($urandom), W'($urandom), 1'($urandom));
    drain();
    send(ALU_ADD, 16'h1111, 16'h2222, 1'b0);
    repeat (2) @(negedge clk);
    #5 reset_n = 1'b0;
    sb.delete();
    #1;
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_alu_cnb", alu_cnb, 1);
    repeat (2) @(negedge clk);
    #5 reset_n = 1'b1;
    @(negedge clk);
    check("abort_req_ready", req_ready, 1);
    check("abort_alu_cnb_rel", alu_cnb, 1);
    hits = 0;
    repeat (12) begin
      @(negedge clk);
      hits += int'(rsp_valid);
    end
    check("abort_no_rsp", hits, 0);
    send(ALU_ADD, 16'h7FFF, 16'h0001, 1'b0);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
